// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, qualifies the synchronized
// locked signal and holds the system in reset until lock is stable.
// Ports:
//   refclk        reference clock (sole clock)
//   rst           synchronous active-high reset
//   pll_locked    PLL locked, asynchronous to refclk
//   clear_stats   pulse, zeroes loss_count and timeout_seen
//   pll_rst       PLL reset, active-high
//   sys_rst       downstream reset, active-high
//   ready         high in RUN
//   state         0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//   loss_count    saturating count of lock losses from RUN
//   timeout_seen  sticky WAIT_LOCK timeout flag
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             clear_stats,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] loss_count,
    output logic             timeout_seen
);

    localparam int MAX_A = (PLL_RST_CYCLES > STABLE_CYCLES) ?
                           PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ?
                           MAX_A : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t          cur;
    state_t          nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            sync1;
    logic            lk;
    logic            loss_ev;
    logic            to_ev;

    // Next-state decode; every state change clears the shared counter.
    always_comb begin
        nxt     = cur;
        cnt_nxt = cnt + 1'b1;
        loss_ev = 1'b0;
        to_ev   = 1'b0;
        unique case (cur)
            S_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    nxt     = S_WAIT_LOCK;
                    cnt_nxt = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    nxt     = S_STABLE;
                    cnt_nxt = '0;
                end else if (cnt == TO_LAST) begin
                    nxt     = S_PLL_RST;
                    cnt_nxt = '0;
                    to_ev   = 1'b1;
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    nxt     = S_WAIT_LOCK;
                    cnt_nxt = '0;
                end else if (cnt == STB_LAST) begin
                    nxt     = S_RUN;
                    cnt_nxt = '0;
                end
            end
            S_RUN: begin
                cnt_nxt = '0;
                if (!lk) begin
                    nxt     = S_PLL_RST;
                    loss_ev = 1'b1;
                end
            end
            default: begin
                nxt     = S_PLL_RST;
                cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            cur          <= S_PLL_RST;
            cnt          <= '0;
            sync1        <= 1'b0;
            lk           <= 1'b0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
            loss_count   <= '0;
            timeout_seen <= 1'b0;
        end else begin
            sync1   <= pll_locked;
            lk      <= sync1;
            cur     <= nxt;
            cnt     <= cnt_nxt;
            pll_rst <= (nxt == S_PLL_RST);
            sys_rst <= (nxt != S_RUN);
            ready   <= (nxt == S_RUN);

            // A same-cycle event beats clear_stats.
            if (loss_ev) begin
                if (clear_stats)
                    loss_count <= CNT_W'(1);
                else if (loss_count != {CNT_W{1'b1}})
                    loss_count <= loss_count + 1'b1;
            end else if (clear_stats) begin
                loss_count <= '0;
            end

            if (to_ev)
                timeout_seen <= 1'b1;
            else if (clear_stats)
                timeout_seen <= 1'b0;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: directed lock/loss/timeout scenarios
// checked against a cycle model and literal expectations.
module tb_pll_lock_sequencer;

    localparam int PRC = 16;
    localparam int STC = 1024;
    localparam int TOC = 100;
    localparam int CW  = 2;
    localparam int LMAX = (1 << CW) - 1;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          clear_stats = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic [1:0]    state;
    logic [CW-1:0] loss_count;
    logic          timeout_seen;

    int total = 0;
    int bad = 0;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES(PRC),
        .STABLE_CYCLES (STC),
        .TIMEOUT_CYCLES(TOC),
        .CNT_W         (CW)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .clear_stats (clear_stats),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .state       (state),
        .loss_count  (loss_count),
        .timeout_seen(timeout_seen)
    );

    always #10 refclk = ~refclk;

    // Model: phase 0..3, elapsed edges in phase, locked history.
    int m_phase = 0;
    int m_el = 0;
    int m_loss = 0;
    int m_to = 0;
    int m_h1 = 0;
    int m_h2 = 0;
    bit m_valid = 1'b0;

    task automatic model_step();
        int lkv;
        bit ev_loss;
        bit ev_to;
        ev_loss = 1'b0;
        ev_to = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_el = 0;
            m_loss = 0;
            m_to = 0;
            m_h1 = 0;
            m_h2 = 0;
            m_valid = 1'b1;
            return;
        end
        lkv = m_h2;
        m_h2 = m_h1;
        m_h1 = int'(pll_locked);
        case (m_phase)
            0: begin
                m_el++;
                if (m_el == PRC) begin
                    m_phase = 1;
                    m_el = 0;
                end
            end
            1: begin
                if (lkv == 1) begin
                    m_phase = 2;
                    m_el = 0;
                end else begin
                    m_el++;
                    if (m_el == TOC) begin
                        m_phase = 0;
                        m_el = 0;
                        ev_to = 1'b1;
                    end
                end
            end
            2: begin
                if (lkv == 0) begin
                    m_phase = 1;
                    m_el = 0;
                end else begin
                    m_el++;
                    if (m_el == STC) begin
                        m_phase = 3;
                        m_el = 0;
                    end
                end
            end
            default: begin
                if (lkv == 0) begin
                    m_phase = 0;
                    m_el = 0;
                    ev_loss = 1'b1;
                end
            end
        endcase
        if (ev_loss)
            m_loss = clear_stats ? 1 :
                     (m_loss < LMAX ? m_loss + 1 : LMAX);
        else if (clear_stats)
            m_loss = 0;
        if (ev_to)
            m_to = 1;
        else if (clear_stats)
            m_to = 0;
    endtask

    initial forever begin
        @(posedge refclk);
        model_step();
    end

    initial forever begin
        @(negedge refclk);
        if (m_valid) begin
            total++;
            if (pll_rst !== (m_phase == 0) ||
                sys_rst !== (m_phase != 3) ||
                ready !== (m_phase == 3) ||
                state !== 2'(m_phase) ||
                loss_count !== CW'(m_loss) ||
                timeout_seen !== (m_to == 1)) begin
                bad++;
                $display("FAIL cycle_check t=%0t dut st=%0d prst=%0b srst=%0b rdy=%0b loss=%0d to=%0b want st=%0d loss=%0d to=%0d",
                         $time, state, pll_rst, sys_rst, ready,
                         loss_count, timeout_seen, m_phase, m_loss, m_to);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input int s, input int lim, input string name);
        int n;
        n = 0;
        while (int'(state) != s && n < lim) begin
            @(negedge refclk);
            n++;
        end
        chk(name, int'(state), s);
    endtask

    task automatic do_loss();
        int n;
        pll_locked = 1'b1;
        wait_state(3, 1300, "t6_run");
        pll_locked = 1'b0;
        n = 0;
        while (!pll_rst && n < 10) begin
            @(negedge refclk);
            n++;
        end
        chk("t6_loss_prst", int'(pll_rst), 1);
    endtask

    initial begin
        int n;
        int r;
        int rt[2];
        int to0;
        int l0;
        logic prev;
        rt[0] = 0;
        rt[1] = 0;
        to0 = -1;
        l0 = -1;

        rst = 1'b1;
        repeat (3) @(negedge refclk);
        chk("rst_state", int'(state), 0);
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_sys_rst", int'(sys_rst), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_loss", int'(loss_count), 0);
        chk("rst_timeout", int'(timeout_seen), 0);

        // T1: PLL reset pulse width
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 40) begin
            n++;
            @(negedge refclk);
        end
        chk("t1_pll_rst_width", n, 16);
        chk("t1_state", int'(state), 1);

        // T2: clean lock latency
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (sys_rst && n < 1100);
        chk("t2_latency", n, 1027);
        chk("t2_ready", int'(ready), 1);
        chk("t2_state", int'(state), 3);

        // T3: one-cycle drop during STABLE restarts qualification
        rst = 1'b1;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        wait_state(2, 40, "t3_enter_stable");
        repeat (500) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        wait_state(1, 10, "t3_back_wait");
        wait_state(2, 10, "t3_restable");
        n = 0;
        while (state == 2'd2 && n < 1100) begin
            n++;
            @(negedge refclk);
        end
        chk("t3_recount", n, 1024);
        chk("t3_state", int'(state), 3);
        chk("t3_loss", int'(loss_count), 0);

        // T4: loss of lock in RUN
        pll_locked = 1'b0;
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (!sys_rst && n < 10);
        chk("t4_react", n, 3);
        chk("t4_loss", int'(loss_count), 1);
        n = 0;
        while (pll_rst && n < 40) begin
            n++;
            @(negedge refclk);
        end
        chk("t4_pll_rst_width", n, 16);
        pll_locked = 1'b1;
        wait_state(3, 1200, "t4_relock");
        chk("t4_ready", int'(ready), 1);

        // T5: timeout re-pulse period and sticky flag
        pll_locked = 1'b0;
        prev = pll_rst;
        r = 0;
        n = 0;
        while (r < 2 && n < 400) begin
            @(negedge refclk);
            n++;
            if (pll_rst && !prev) begin
                rt[r] = n;
                if (r == 0) begin
                    to0 = int'(timeout_seen);
                    l0 = int'(loss_count);
                end
                r++;
            end
            prev = pll_rst;
        end
        chk("t5_rises", r, 2);
        chk("t5_period", rt[1] - rt[0], 116);
        chk("t5_to_before", to0, 0);
        chk("t5_loss", l0, 2);
        chk("t5_to_after", int'(timeout_seen), 1);
        clear_stats = 1'b1;
        @(negedge refclk);
        clear_stats = 1'b0;
        chk("t5_clear_to", int'(timeout_seen), 0);
        chk("t5_clear_loss", int'(loss_count), 0);

        // T6: saturation and clear colliding with a loss
        repeat (5) do_loss();
        chk("t6_sat", int'(loss_count), 3);
        pll_locked = 1'b1;
        wait_state(3, 1300, "t6_run_last");
        pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        clear_stats = 1'b1;
        @(negedge refclk);
        clear_stats = 1'b0;
        chk("t6_clear_vs_loss", int'(loss_count), 1);
        chk("t6_clear_prst", int'(pll_rst), 1);
        repeat (3) @(negedge refclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
